alu1: RTL and testbench
=======================

// Module: alu1
// PURPOSE
//   Registered 32-bit combinational-core ALU: 16 operations on operands a and y,
//   selected by alu_sel; result and carry/borrow captured on the rising clock edge.
//   Sits as a datapath execution unit; one result per cycle, no handshake.
// PARAMETERS
//   WIDTH   32   operand/result width in bits (all rules below use WIDTH; spec values assume 32)
// PORTS
//   clk       in   1      single clock, rising-edge active
//   rst       in   1      asynchronous, active-high reset
//   a         in   WIDTH  operand A (unsigned)
//   y         in   WIDTH  operand B (unsigned)
//   alu_sel   in   4      operation select
//   alu_out   out  WIDTH  registered result
//   carryout  out  1      registered carry/borrow flag
// BEHAVIOUR
//   - One clock domain; reset is asynchronous and active-high. While rst=1 (asserted any
//     time, incl. mid-operation): alu_out=0, carryout=0 immediately, independent of clk.
//   - Latency 1: inputs sampled at rising clk; alu_out/carryout valid after that edge,
//     held until next edge. New op accepted every cycle; no stall, no valid signal.
//   - Opcode map (all operands unsigned, results truncated to WIDTH):
//       0 ADD  a+y            carryout = bit WIDTH of the WIDTH+1 sum
//       1 SUB  a-y (mod 2^W)  carryout = 1 iff a<y (borrow)
//       2 MUL  low WIDTH bits of a*y
//       3 DIV  a/y; y==0 -> alu_out = all ones
//       4 SHL  a<<1 (zero fill)
//       5 SHR  a>>1 (logical, zero fill)
//       6 ROL  a rotated left by 1
//       7 ROR  a rotated right by 1
//       8 AND  a&y     9 OR  a|y     10 XOR  a^y
//      11 NOR ~(a|y)  12 NAND ~(a&y) 13 XNOR ~(a^y)
//      14 GT   1 if a>y else 0 (zero-extended)
//      15 EQ   1 if a==y else 0 (zero-extended)
//   - carryout = 0 for every opcode other than ADD and SUB.
//   - alu_sel is 4 bits; any increment past 15 wraps to 0 (ADD) -- no illegal opcodes.
//   - No X propagation: every alu_sel value drives a defined result.
// TESTING
//   - Reset: assert rst between edges with a=32,y=2,alu_sel=0 -> alu_out=0,carryout=0
//     immediately; release, next edge -> alu_out=34.
//   - Sweep a=32,y=2, alu_sel 0..15 one per cycle -> 34,30,64,16,64,16,64,16,0,34,34,
//     0xFFFFFFDD,0xFFFFFFFF,0xFFFFFFDD,1,0; carryout=0 throughout.
//   - Carry/borrow: ADD a=0xFFFFFFFF,y=1 -> 0,carry=1; SUB a=21,y=24 -> 0xFFFFFFFD,carry=1;
//     SUB a=24,y=21 -> 3,carry=0.
//   - Edges: DIV y=0 -> 0xFFFFFFFF; ROL a=0x80000001 -> 0x00000003; ROR a=1 -> 0x80000000;
//     SHL a=0x80000000 -> 0.
//   - Compare: a=24,y=21 -> GT=1, EQ=0; a=y=7 -> GT=0, EQ=1; MUL a=0x10000,y=0x10000 -> 0.
//   - Wrap: alu_sel 15 -> 0 increment gives ADD result next cycle; output changes only
//     on rising clk edges.

Source files
------------

// File: rtl/alu1.sv
// alu1: registered 16-operation ALU over unsigned operands a and y.
//   clk      in  rising-edge clock
//   rst      in  asynchronous active-high reset, clears alu_out and carryout
//   a        in  WIDTH operand A
//   y        in  WIDTH operand B
//   alu_sel  in  4-bit operation select
//   alu_out  out WIDTH registered result
//   carryout out registered carry (ADD) / borrow (SUB), 0 for all other ops
module alu1 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] y,
   input  logic [3:0]       alu_sel,
   output logic [WIDTH-1:0] alu_out,
   output logic             carryout
);
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             c;
   assign sum = {1'b0, a} + {1'b0, y};
   always_comb begin
      c = 1'b0;
      case (alu_sel)
         4'd0:    begin res = sum[WIDTH-1:0]; c = sum[WIDTH]; end
         4'd1:    begin res = a - y; c = a < y; end
         4'd2:    res = a * y;
         4'd3:    res = (y == '0) ? '1 : a / y;
         4'd4:    res = a << 1;
         4'd5:    res = a >> 1;
         4'd6:    res = {a[WIDTH-2:0], a[WIDTH-1]};
         4'd7:    res = {a[0], a[WIDTH-1:1]};
         4'd8:    res = a & y;
         4'd9:    res = a | y;
         4'd10:   res = a ^ y;
         4'd11:   res = ~(a | y);
         4'd12:   res = ~(a & y);
         4'd13:   res = ~(a ^ y);
         4'd14:   res = WIDTH'(a > y);
         default: res = WIDTH'(a == y);
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         alu_out  <= '0;
         carryout <= 1'b0;
      end else begin
         alu_out  <= res;
         carryout <= c;
      end
endmodule

// File: tb/tb_alu1.sv
// tb_alu1: directed self-checking bench for alu1.
module tb_alu1;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] y = '0;
   logic [3:0]  alu_sel = '0;
   logic [31:0] alu_out;
   logic        carryout;
   int checks = 0;
   int errors = 0;

   alu1 dut (.clk(clk), .rst(rst), .a(a), .y(y), .alu_sel(alu_sel),
             .alu_out(alu_out), .carryout(carryout));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] eo, input logic ec);
      checks++;
      assert (alu_out === eo && carryout === ec) else begin
         errors++;
         $error("FAIL %s: out=%h carry=%b expected out=%h carry=%b", tag, alu_out, carryout, eo, ec);
      end
   endtask

   task automatic step(input logic [31:0] ta, input logic [31:0] ty, input logic [3:0] ts,
                       input logic [31:0] eo, input logic ec, input string tag);
      @(negedge clk);
      a = ta; y = ty; alu_sel = ts;
      @(posedge clk);
      #1 chk(tag, eo, ec);
   endtask

   initial begin
      logic [31:0] sweep [16];
      sweep = '{32'd34, 32'd30, 32'd64, 32'd16, 32'd64, 32'd16, 32'd64, 32'd16,
                32'd0, 32'd34, 32'd34, 32'hFFFFFFDD, 32'hFFFFFFFF, 32'hFFFFFFDD, 32'd1, 32'd0};
      a = 32'd32; y = 32'd2; alu_sel = 4'd0;
      @(posedge clk);
      #1 chk("reset_hold", 32'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("post_reset_add", 32'd34, 1'b0);
      // asynchronous reset between edges
      @(negedge clk);
      rst = 1'b1;
      #1 chk("async_reset", 32'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("release_add", 32'd34, 1'b0);
      for (int i = 0; i < 16; i++)
         step(32'd32, 32'd2, 4'(i), sweep[i], 1'b0, $sformatf("sweep_op%0d", i));
      step(32'hFFFFFFFF, 32'd1, 4'd0, 32'd0, 1'b1, "add_carry");
      step(32'd21, 32'd24, 4'd1, 32'hFFFFFFFD, 1'b1, "sub_borrow");
      step(32'd24, 32'd21, 4'd1, 32'd3, 1'b0, "sub_noborrow");
      step(32'd100, 32'd0, 4'd3, 32'hFFFFFFFF, 1'b0, "div_by_zero");
      step(32'd100, 32'd7, 4'd3, 32'd14, 1'b0, "div_normal");
      step(32'h80000001, 32'd0, 4'd6, 32'h00000003, 1'b0, "rol_wrap");
      step(32'd1, 32'd0, 4'd7, 32'h80000000, 1'b0, "ror_wrap");
      step(32'h80000000, 32'd0, 4'd4, 32'd0, 1'b0, "shl_out");
      step(32'h80000000, 32'd0, 4'd5, 32'h40000000, 1'b0, "shr_msb");
      step(32'd24, 32'd21, 4'd14, 32'd1, 1'b0, "gt_true");
      step(32'd24, 32'd21, 4'd15, 32'd0, 1'b0, "eq_false");
      step(32'd7, 32'd7, 4'd14, 32'd0, 1'b0, "gt_equal");
      step(32'd7, 32'd7, 4'd15, 32'd1, 1'b0, "eq_true");
      step(32'h10000, 32'h10000, 4'd2, 32'd0, 1'b0, "mul_trunc");
      step(32'hF0F0F0F0, 32'h0FF00FF0, 4'd10, 32'hFF00FF00, 1'b0, "xor_pattern");
      // opcode wrap 15 -> 0, output held until the next rising edge
      step(32'd5, 32'd5, 4'd15, 32'd1, 1'b0, "wrap_eq");
      @(negedge clk);
      alu_sel = alu_sel + 4'd1;
      #1 chk("hold_between_edges", 32'd1, 1'b0);
      @(posedge clk);
      #1 chk("wrap_add", 32'd10, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
